// File: rtl/hub75_rx_monitor.sv
// HUB75 panel-side receiver: oversamples the panel pins, rebuilds the latched row
// and emits one record per OE_n-low display interval.
module hub75_rx_monitor #(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int segments_p = 2,
  parameter int cnt_w_p    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_hub_clk,
  input  logic                                 i_hub_lat,
  input  logic                                 i_hub_oe_n,
  input  logic [$clog2(vpixel_p)-1:0]          i_hub_addr,
  input  logic [3*segments_p-1:0]              i_hub_rgb,
  input  logic                                 i_clear,
  input  logic                                 i_ready,
  output logic                                 o_valid,
  output logic [$clog2(vpixel_p)-1:0]          o_row,
  output logic [cnt_w_p-1:0]                   o_on_cycles,
  output logic [$clog2(hpixel_p):0]            o_shift_cnt,
  output logic [hpixel_p*3*segments_p-1:0]     o_data,
  output logic                                 o_cnt_err,
  output logic                                 o_lat_err,
  output logic                                 o_addr_err,
  output logic                                 o_overflow
);

  // state | meaning
  // IDLE  | OE_n high, waiting for a display interval
  // ON    | OE_n low, counting on-time and watching for LAT/address faults
  // EMIT  | interval ended, record handed to the output slot this cycle
  typedef enum logic [1:0] {st_idle, st_on, st_emit} state_t;

  localparam int aw_l = $clog2(vpixel_p);
  localparam int rw_l = 3 * segments_p;
  localparam int sw_l = $clog2(hpixel_p) + 1;
  localparam int dw_l = hpixel_p * rw_l;
  localparam logic [sw_l-1:0] full_l = sw_l'(hpixel_p);

  state_t state, state_nxt;

  logic [2:0]      clk_sr, lat_sr, oe_sr;
  logic [aw_l-1:0] addr_s1, addr_s2;
  logic [rw_l-1:0] rgb_s1, rgb_s2;

  logic            clk_rise, lat_rise, oe_fall, oe_rise, oe_low;

  logic [dw_l-1:0] shreg, shreg_nxt, lat_data;
  logic [sw_l-1:0] shift_cnt, cnt_nxt, lat_cnt;
  logic [aw_l-1:0] row_q;
  logic [cnt_w_p-1:0] on_cnt;

  logic            cnt_err_set, lat_err_set, addr_err_set, ovf_set;

  // Sync chains reset to idle pin levels so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sr  <= 3'b000;
      lat_sr  <= 3'b000;
      oe_sr   <= 3'b111;
      addr_s1 <= '0;
      addr_s2 <= '0;
      rgb_s1  <= '0;
      rgb_s2  <= '0;
    end else begin
      clk_sr  <= {clk_sr[1:0], i_hub_clk};
      lat_sr  <= {lat_sr[1:0], i_hub_lat};
      oe_sr   <= {oe_sr[1:0], i_hub_oe_n};
      addr_s1 <= i_hub_addr;
      addr_s2 <= addr_s1;
      rgb_s1  <= i_hub_rgb;
      rgb_s2  <= rgb_s1;
    end
  end

  assign clk_rise = clk_sr[1] & ~clk_sr[2];
  assign lat_rise = lat_sr[1] & ~lat_sr[2];
  assign oe_fall  = ~oe_sr[1] & oe_sr[2];
  assign oe_rise  = oe_sr[1] & ~oe_sr[2];
  assign oe_low   = ~oe_sr[1];

  // A shift coinciding with a latch is applied first, so the latch sees it.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = shift_cnt;
    if (clk_rise) begin
      shreg_nxt = {rgb_s2, shreg[dw_l-1:rw_l]};
      if (shift_cnt != '1) cnt_nxt = shift_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      shift_cnt <= '0;
      lat_data  <= '0;
      lat_cnt   <= '0;
    end else begin
      shreg <= shreg_nxt;
      if (lat_rise) begin
        lat_data  <= shreg_nxt;
        lat_cnt   <= cnt_nxt;
        shift_cnt <= '0;
      end else begin
        shift_cnt <= cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= st_idle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle: if (oe_fall) state_nxt = st_on;
      st_on:   if (oe_rise) state_nxt = st_emit;
      st_emit: state_nxt = oe_fall ? st_on : st_idle;
      default: state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      on_cnt <= '0;
    end else if ((state == st_idle || state == st_emit) && oe_fall) begin
      row_q  <= addr_s2;
      on_cnt <= cnt_w_p'(1);
    end else if (state == st_on && !oe_rise && on_cnt != '1) begin
      on_cnt <= on_cnt + 1'b1;
    end
  end

  assign cnt_err_set  = lat_rise && (cnt_nxt != full_l);
  assign lat_err_set  = lat_rise && oe_low;
  assign addr_err_set = (state == st_on) && oe_low && (addr_s2 != row_q);
  assign ovf_set      = (state == st_emit) && o_valid && !i_ready;

  // Sticky flags: a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_cnt_err  <= 1'b0;
      o_lat_err  <= 1'b0;
      o_addr_err <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_cnt_err  <= (o_cnt_err  & ~i_clear) | cnt_err_set;
      o_lat_err  <= (o_lat_err  & ~i_clear) | lat_err_set;
      o_addr_err <= (o_addr_err & ~i_clear) | addr_err_set;
      o_overflow <= (o_overflow & ~i_clear) | ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_row       <= '0;
      o_on_cycles <= '0;
      o_shift_cnt <= '0;
      o_data      <= '0;
    end else if (state == st_emit && (!o_valid || i_ready)) begin
      o_valid     <= 1'b1;
      o_row       <= row_q;
      o_on_cycles <= on_cnt;
      o_shift_cnt <= lat_cnt;
      o_data      <= lat_data;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
